// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding unit: EX operand
// mux select encodings and the stall controller state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MUL_BUSY = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit_fwd_match.sv
// One source-operand slot: compares the operand address against the MEM and
// WB producers and returns the operand mux select (MEM wins over WB).
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              need_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic              mem_fwd_i,
    input  logic [REG_AW-1:0] mem_rdst_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rdst_i,
    output logic [1:0]        sel_o
);

    logic mem_hit;
    logic wb_hit;

    // a write to r0 is discarded, so it must never look like a producer
    assign mem_hit = need_i && mem_fwd_i && (rs_i == mem_rdst_i)
                     && !(R0_ZERO && (mem_rdst_i == '0));
    assign wb_hit  = need_i && wb_we_i && (rs_i == wb_rdst_i)
                     && !(R0_ZERO && (wb_rdst_i == '0));

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding for the 5-stage pipeline: EX/ID operand
// bypass selects, load-use / memory-wait / multi-cycle EX stalls, stall counter.
//
// state    | meaning
// IDLE     | no stall pending; evaluate memory wait, multi-cycle op, load-use
// MEM_WAIT | MEM-stage load waiting on mem_ready; back half freezes too
// MUL_BUSY | multi-cycle EX op running; front frozen, bubbles into EX/MEM
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MUL_LAT = 3,
    parameter bit R0_ZERO = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        ifid_need_i,
    input  logic [NUM_SRC*REG_AW-1:0] ifid_rs_i,
    input  logic [NUM_SRC-1:0]        idex_need_i,
    input  logic [NUM_SRC*REG_AW-1:0] idex_rs_i,
    input  logic                      idex_mul_i,
    input  logic                      exmem_we_i,
    input  logic                      exmem_is_load_i,
    input  logic [REG_AW-1:0]         exmem_rdst_i,
    input  logic                      mem_ready_i,
    input  logic                      memwb_we_i,
    input  logic [REG_AW-1:0]         memwb_rdst_i,
    output logic [2*NUM_SRC-1:0]      ex_fwd_sel_o,
    output logic [NUM_SRC-1:0]        id_fwd_wb_o,
    output logic                      hold_front_o,
    output logic                      bubble_mem_o,
    output logic                      hold_mem_o,
    output logic                      bubble_wb_o,
    output logic                      mul_done_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [MCW-1:0] MUL_LAST = MCW'((MUL_LAT > 1) ? MUL_LAT - 1 : 0);

    hz_state_e        state_q, state_d;
    logic [MCW-1:0]   mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic mem_wait, mul_req, lu;
    logic hold_front, bubble_mem, hold_mem, bubble_wb, mul_done;

    // a load result is not available for EX/MEM forwarding, only from WB
    logic mem_fwd;
    assign mem_fwd = exmem_we_i && !exmem_is_load_i;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [1:0] id_sel;

        fwd_match #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_ex_match (
            .need_i     (idex_need_i[i]),
            .rs_i       (idex_rs_i[i*REG_AW +: REG_AW]),
            .mem_fwd_i  (mem_fwd),
            .mem_rdst_i (exmem_rdst_i),
            .wb_we_i    (memwb_we_i),
            .wb_rdst_i  (memwb_rdst_i),
            .sel_o      (ex_fwd_sel_o[2*i +: 2])
        );

        fwd_match #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_id_match (
            .need_i     (ifid_need_i[i]),
            .rs_i       (ifid_rs_i[i*REG_AW +: REG_AW]),
            .mem_fwd_i  (1'b0),
            .mem_rdst_i (exmem_rdst_i),
            .wb_we_i    (memwb_we_i),
            .wb_rdst_i  (memwb_rdst_i),
            .sel_o      (id_sel)
        );

        assign id_fwd_wb_o[i] = (id_sel == FWD_WB);
    end

    assign mem_wait = exmem_is_load_i && !mem_ready_i;
    assign mul_req  = idex_mul_i && (MUL_LAT > 1);

    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idex_need_i[i] && (idex_rs_i[i*REG_AW +: REG_AW] == exmem_rdst_i))
                lu = 1'b1;
        end
        lu = lu && exmem_is_load_i && exmem_we_i && mem_ready_i
             && !(R0_ZERO && (exmem_rdst_i == '0));
    end

    always_comb begin
        state_d    = state_q;
        mcnt_d     = mcnt_q;
        hold_front = 1'b0;
        bubble_mem = 1'b0;
        hold_mem   = 1'b0;
        bubble_wb  = 1'b0;
        mul_done   = 1'b0;
        unique case (state_q)
            MUL_BUSY: begin
                hold_front = 1'b1;
                bubble_mem = 1'b1;
                if (mem_wait) begin
                    hold_mem  = 1'b1;
                    bubble_wb = 1'b1;
                end else if (mcnt_q == MUL_LAST) begin
                    hold_front = 1'b0;
                    bubble_mem = 1'b0;
                    mul_done   = 1'b1;
                    mcnt_d     = '0;
                    state_d    = IDLE;
                end else begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            // MEM_WAIT with memory now ready behaves exactly like IDLE
            default: begin
                if (mem_wait) begin
                    hold_front = 1'b1;
                    hold_mem   = 1'b1;
                    bubble_wb  = 1'b1;
                    state_d    = MEM_WAIT;
                end else if (mul_req) begin
                    hold_front = 1'b1;
                    bubble_mem = 1'b1;
                    mcnt_d     = MCW'(1);
                    state_d    = MUL_BUSY;
                end else begin
                    state_d = IDLE;
                    if (lu) begin
                        hold_front = 1'b1;
                        bubble_mem = 1'b1;
                    end
                end
            end
        endcase
    end

    assign hold_front_o = hold_front && !rst;
    assign bubble_mem_o = bubble_mem && !rst;
    assign hold_mem_o   = hold_mem && !rst;
    assign bubble_wb_o  = bubble_wb && !rst;
    assign mul_done_o   = mul_done && !rst;

    always_comb begin
        stall_d = stall_q;
        if (hold_front_o && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard and forwarding unit for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generalises per-operand forwarding to NUM_SRC source operands and a configurable register-address width.
- Adds a stall/bubble state machine for load-use hazards, multi-cycle data-memory waits (mem_ready handshake) and a fixed-latency multi-cycle EX unit.
- Includes a saturating stall-cycle performance counter.
- Sits beside the pipeline registers and drives the EX operand muxes, the ID-stage WB bypass and the pipeline freeze/bubble controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction
MUL_LAT, 3, EX cycles taken by a multi-cycle op (1 = single-cycle, no stall)
R0_ZERO, 1, register 0 hardwired zero: never forwarded, never causes a hazard
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ifid_need  in  NUM_SRC  source i of ID-stage instruction is read
ifid_rs  in  NUM_SRC*REG_AW  ID-stage source addresses, slot i at [i*REG_AW +: REG_AW]
idex_need  in  NUM_SRC  source i of EX-stage instruction is read
idex_rs  in  NUM_SRC*REG_AW  EX-stage source addresses
idex_mul  in  1  EX-stage instruction is multi-cycle
exmem_we  in  1  MEM-stage instruction writes a register
exmem_is_load  in  1  MEM-stage instruction is a load
exmem_rdst  in  REG_AW  MEM-stage destination
mem_ready  in  1  data memory completes the MEM-stage access this cycle
memwb_we  in  1  WB-stage instruction writes a register
memwb_rdst  in  REG_AW  WB-stage destination
ex_fwd_sel  out  2*NUM_SRC  per-source EX mux select: 00 regfile, 01 MEM/WB, 10 EX/MEM
id_fwd_wb  out  NUM_SRC  per-source ID bypass from WB
hold_front  out  1  freeze PC, IF/ID, ID/EX
bubble_mem  out  1  load NOP into EX/MEM
hold_mem  out  1  freeze EX/MEM
bubble_wb  out  1  load NOP into MEM/WB
mul_done  out  1  multi-cycle op result valid this cycle
stall_cnt  out  CNT_W  total stalled cycles, saturating

Behaviour:
- match(a,d) = (a==d) && !(R0_ZERO && d==0).
- ex_fwd_sel[i] (combinational):
  - 10 if exmem_we && !exmem_is_load && idex_need[i] && match;
  - else 01 if memwb_we && idex_need[i] && match;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- id_fwd_wb[i] = memwb_we && ifid_need[i] && match(ifid_rs[i], memwb_rdst).
- Events, in priority order:
  - mem_wait = exmem_is_load && !mem_ready.
  - mul_req = idex_mul && MUL_LAT>1.
  - lu = exmem_is_load && exmem_we && mem_ready && any i: idex_need[i] && match(idex_rs[i], exmem_rdst).
- FSM states, registered:
  - IDLE:
    - mem_wait -> MEM_WAIT: hold_front=1, hold_mem=1, bubble_wb=1 in that same cycle (combinational).
    - else mul_req -> MUL_BUSY: cnt<=1; hold_front=1, bubble_mem=1.
    - else lu: hold_front=1, bubble_mem=1 for exactly this cycle; FSM stays IDLE. Next cycle the load is in MEM/WB and the 01 forward resolves the hazard.
  - MEM_WAIT: hold_front, hold_mem, bubble_wb=1 while !mem_ready.
    - On mem_ready, outputs are evaluated as in IDLE and the FSM -> IDLE in the same cycle.
    - lu re-check is permitted: a load waiting with a dependent consumer produces one extra bubble.
  - MUL_BUSY: hold_front=1, bubble_mem=1; cnt increments.
    - When cnt==MUL_LAT-1: mul_done=1, stalls drop, -> IDLE.
    - mem_wait arriving during MUL_BUSY additionally asserts hold_mem and bubble_wb and freezes cnt.
- Total stall latency: load-use 1 cycle; multi-cycle op MUL_LAT-1 cycles; memory wait = cycles with mem_ready low.
- stall_cnt increments each cycle that hold_front=1; it saturates at all-ones and does not wrap.
- Reset (also mid-operation):
  - state=IDLE, cnt=0, stall_cnt=0.
  - While rst=1, hold_front, bubble_mem, hold_mem, bubble_wb and mul_done are forced 0.
  - ex_fwd_sel and id_fwd_wb stay combinational.

Decomposition:
- Shared package hazard_pkg:
  - fwd select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state enum {IDLE, MEM_WAIT, MUL_BUSY}.
- One natural sub-module: fwd_match (one source slot: need, address, two producers -> 2-bit select), instantiated NUM_SRC times by generate.

Test Plan:
- add r3 in MEM (we=1, not load), consumer in EX with rs0=3, need=01 -> ex_fwd_sel[1:0]=10; same rdst also in WB -> still 10; MEM rdst=4, WB rdst=3 -> 01.
- R0_ZERO=1, exmem_rdst=0, idex_rs0=0 -> sel 00, no stall; load to r0 with dependent consumer -> no bubble.
- Load r5 in MEM, mem_ready=1, EX source1=5 -> hold_front=1, bubble_mem=1 for 1 cycle; next cycle the load is in WB -> sel[3:2]=01, no stall; stall_cnt=1.
- Load with mem_ready low 3 cycles -> hold_mem=bubble_wb=hold_front=1 for 3 cycles, released on the cycle mem_ready=1; stall_cnt=3.
- MUL_LAT=3, idex_mul=1 -> hold_front 2 cycles, mul_done on the 2nd; MUL_LAT=1 -> no stall. rst asserted in MUL_BUSY -> next cycle all stalls 0, stall_cnt=0.
- CNT_W=4, sustained stall 20 cycles -> stall_cnt saturates at 15.
